// File: rtl/slide_pot_sequencer.sv
// Round-robin A2D sequencer for the slide pots: one conversion per band, then an
// optional first-order IIR (shift k) into a registered 12-bit value per band.
//
// state | meaning
// GAP   | idle spacing between conversions, counts SAMPLE_GAP clocks
// REQ   | single-cycle strt_cnv for the current band's channel
// WAIT  | waiting for cnv_cmplt, bounded by the timeout counter
// ADV   | step to the next band; pulses sweep_done after the last band

module slide_pot_sequencer #(
  parameter int NUM_BANDS    = 5,
  parameter int CH_BASE      = 0,
  parameter int SAMPLE_GAP   = 1024,
  parameter int TIMEOUT      = 4096,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      strt_cnv,
  output logic [2:0]                chnnl,
  input  logic                      cnv_cmplt,
  input  logic [11:0]               res,
  output logic [12*NUM_BANDS-1:0]   pots,
  output logic                      sweep_done,
  output logic                      to_err
);

  localparam int GW = $clog2(SAMPLE_GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SAMPLE_GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_BANDS - 1);
  localparam logic [2:0]    CH0      = 3'(CH_BASE);

  typedef enum logic [1:0] {ST_GAP, ST_REQ, ST_WAIT, ST_ADV} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           chnnl_q, chnnl_d;
  logic                 to_err_q, to_err_d;
  logic [11:0]          pots_q [NUM_BANDS];
  logic [11:0]          pots_d [NUM_BANDS];
  logic [NUM_BANDS-1:0] loaded_q, loaded_d;

  logic                 cap;
  logic [11:0]          cur_pot;
  logic                 cur_loaded;
  logic signed [12:0]   diff;
  logic [11:0]          step;
  logic [11:0]          smooth_val;
  logic [11:0]          new_val;

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    idx_d      = idx_q;
    chnnl_d    = chnnl_q;
    to_err_d   = to_err_q;
    cap        = 1'b0;
    strt_cnv   = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_REQ;
          chnnl_d = CH0 + idx_q;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_REQ: begin
        strt_cnv  = 1'b1;
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // a completion on the expiry cycle still wins over the timeout
        if (cnv_cmplt) begin
          cap     = 1'b1;
          state_d = ST_ADV;
        end else if (tmo_cnt_q == TMO_LAST) begin
          to_err_d = 1'b1;
          state_d  = ST_ADV;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_ADV: begin
        gap_cnt_d = '0;
        state_d   = ST_GAP;
        if (idx_q == IDX_LAST) begin
          idx_d      = '0;
          sweep_done = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

  always_comb begin
    cur_pot    = '0;
    cur_loaded = 1'b0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_pot    = pots_q[i];
        cur_loaded = loaded_q[i];
      end
    end
    diff = $signed({1'b0, res}) - $signed({1'b0, cur_pot});
    // low 12 bits of the 13-bit sum; the true result never leaves 0..4095
    step       = 12'(diff >>> SMOOTH_SHIFT);
    smooth_val = cur_pot + step;
    new_val    = (!cur_loaded || SMOOTH_SHIFT == 0) ? res : smooth_val;
    for (int i = 0; i < NUM_BANDS; i++) begin
      pots_d[i]   = pots_q[i];
      loaded_d[i] = loaded_q[i];
      if (cap && idx_q == 3'(i)) begin
        pots_d[i]   = new_val;
        loaded_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_GAP;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
      idx_q     <= '0;
      chnnl_q   <= CH0;
      to_err_q  <= 1'b0;
      loaded_q  <= '0;
      for (int i = 0; i < NUM_BANDS; i++) pots_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      idx_q     <= idx_d;
      chnnl_q   <= chnnl_d;
      to_err_q  <= to_err_d;
      loaded_q  <= loaded_d;
      for (int i = 0; i < NUM_BANDS; i++) pots_q[i] <= pots_d[i];
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_pots
    assign pots[12*g +: 12] = pots_q[g];
  end

  assign chnnl  = chnnl_q;
  assign to_err = to_err_q;

endmodule

// File: tb/tb_slide_pot_sequencer.sv
// Randomized bench for slide_pot_sequencer: a timeline model of request/response
// cycles predicts every output on every cycle, plus literal checks per scenario.

module tb_slide_pot_sequencer;

  localparam int NB = 5;
  localparam int CB = 0;
  localparam int SG = 4;
  localparam int TO = 8;
  localparam int K  = 2;
  localparam int PW = 12 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          strt_cnv;
  logic [2:0]    chnnl;
  logic          cnv_cmplt = 1'b0;
  logic [11:0]   res = '0;
  logic [PW-1:0] pots;
  logic          sweep_done;
  logic          to_err;

  slide_pot_sequencer #(
    .NUM_BANDS(NB), .CH_BASE(CB), .SAMPLE_GAP(SG), .TIMEOUT(TO), .SMOOTH_SHIFT(K)
  ) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .pots(pots),
    .sweep_done(sweep_done), .to_err(to_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: cycle numbers count from the reset edge (cycle 0)
  int          cyc, next_req, req_cyc, resp_cyc, end_cyc, sweep_cyc, band, first_strt;
  bit          in_conv, resp_ok, noise_en;
  logic [11:0] resp_val;
  logic [11:0] m_pots [NB];
  bit          m_loaded [NB];
  bit          m_err;
  logic [2:0]  m_chnnl;
  int          force_lat [NB];  // -1 silent, -2 random incl. timeouts, -3 random success, >=0 fixed
  int          force_res [NB];  // -1 random, else fixed value
  logic [2:0]  chq [$];

  logic [PW-1:0] obs_pots;
  logic          obs_strt, obs_err, obs_sweep;
  logic [2:0]    obs_chnnl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    next_req   = SG;
    sweep_cyc  = -1;
    band       = 0;
    in_conv    = 0;
    first_strt = -1;
    m_err      = 0;
    m_chnnl    = 3'(CB);
    for (int i = 0; i < NB; i++) begin
      m_pots[i]   = '0;
      m_loaded[i] = 0;
    end
    chq.delete();
  endtask

  task automatic set_all(input int lat, input int rv);
    for (int i = 0; i < NB; i++) begin
      force_lat[i] = lat;
      force_res[i] = rv;
    end
  endtask

  task automatic do_reset(input bit pulse);
    @(negedge clk);
    rst       = 1'b1;
    cnv_cmplt = pulse;
    res       = 12'($urandom);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cnv_cmplt = 1'b0;
    model_reset();
  endtask

  task automatic plan_conv();
    int lat;
    int fl;
    fl      = force_lat[band];
    lat     = 0;
    req_cyc = cyc;
    in_conv = 1;
    if (fl == -1 || (fl == -2 && $urandom_range(0, 7) == 0)) begin
      resp_ok = 0;
    end else begin
      resp_ok = 1;
      if (fl >= 0) lat = fl;
      else if ($urandom_range(0, 3) == 0) lat = TO - 1;
      else lat = int'($urandom_range(0, TO - 1));
    end
    resp_val = (force_res[band] >= 0) ? 12'(force_res[band]) : 12'($urandom);
    resp_cyc = resp_ok ? cyc + 1 + lat : -1;
    end_cyc  = resp_ok ? resp_cyc : cyc + TO;
  endtask

  task automatic finish_conv();
    int d;
    if (resp_ok) begin
      if (!m_loaded[band] || K == 0) begin
        m_pots[band] = resp_val;
      end else begin
        d = int'(resp_val) - int'(m_pots[band]);
        m_pots[band] = 12'(int'(m_pots[band]) + (d >>> K));
      end
      m_loaded[band] = 1;
    end else begin
      m_err = 1;
    end
    if (band == NB - 1) sweep_cyc = cyc + 1;
    band     = (band + 1) % NB;
    next_req = cyc + 2 + SG;
    in_conv  = 0;
  endtask

  // one clock of the compare process: predict, compare, drive, advance model
  task automatic step();
    logic [PW-1:0] exp_pots;
    @(negedge clk);
    if (cyc == next_req) begin
      m_chnnl = 3'(CB + band);
      plan_conv();
    end
    for (int i = 0; i < NB; i++) exp_pots[12*i +: 12] = m_pots[i];
    obs_pots  = pots;
    obs_strt  = strt_cnv;
    obs_err   = to_err;
    obs_sweep = sweep_done;
    obs_chnnl = chnnl;
    if (strt_cnv === 1'b1) begin
      chq.push_back(chnnl);
      if (first_strt < 0) first_strt = cyc;
    end
    chk("strt_cnv", 64'(strt_cnv), 64'(cyc == next_req));
    chk("chnnl", 64'(chnnl), 64'(m_chnnl));
    chk("sweep_done", 64'(sweep_done), 64'(cyc == sweep_cyc));
    chk("to_err", 64'(to_err), 64'(m_err));
    chk("pots", 64'(pots), 64'(exp_pots));
    cnv_cmplt = 1'b0;
    res       = 12'($urandom);
    if (in_conv && cyc > req_cyc) begin
      if (resp_ok && cyc == resp_cyc) begin
        cnv_cmplt = 1'b1;
        res       = resp_val;
      end
    end else if (noise_en && $urandom_range(0, 5) == 0) begin
      cnv_cmplt = 1'b1;
    end
    if (in_conv && cyc == end_cyc) finish_conv();
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_sweep();
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 400) begin
      seen = (cyc == sweep_cyc);
      step();
      n++;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL sweep_wait: no sweep_done within 400 cycles (got none, expected one)");
    end
  endtask

  task automatic run_to_strt();
    int n;
    n = 0;
    obs_strt = 1'b0;
    while (obs_strt !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("strt_wait", 64'(obs_strt), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    noise_en = 0;
    set_all(-3, -1);

    // first load, first request timing
    force_lat[0] = 0;
    force_res[0] = 12'hFFF;
    do_reset(0);
    run_cycles(1);
    chk("rst_pots", 64'(obs_pots), 64'(0));
    chk("rst_strt", 64'(obs_strt), 64'(0));
    chk("rst_chnnl", 64'(obs_chnnl), 64'(0));
    chk("rst_err", 64'(obs_err), 64'(0));
    run_cycles(4);
    chk("first_strt_cycle", 64'(first_strt), 64'(4));
    chk("first_chnnl", 64'(obs_chnnl), 64'(0));
    run_cycles(2);
    chk("first_load", 64'(obs_pots[11:0]), 64'(12'hFFF));

    // full sweep with res = 100*(ch+1)
    set_all(-3, -1);
    for (int i = 0; i < NB; i++) force_res[i] = 100 * (i + 1);
    do_reset(0);
    run_to_sweep();
    chk("sweep_len", 64'(chq.size()), 64'(NB));
    for (int i = 0; i < NB && i < chq.size(); i++) chk("sweep_chnnl", 64'(chq[i]), 64'(i));
    for (int i = 0; i < NB; i++) chk("sweep_pot", 64'(obs_pots[12*i +: 12]), 64'(100 * (i + 1)));
    chk("sweep_pulse", 64'(obs_sweep), 64'(1));
    run_to_strt();
    chk("restart_chnnl", 64'(obs_chnnl), 64'(0));

    // smoothing k=2 on band 0
    set_all(-3, -1);
    force_res[0] = 0;
    do_reset(0);
    run_to_sweep();
    chk("smooth_load0", 64'(obs_pots[11:0]), 64'(0));
    force_res[0] = 12'h400;
    run_to_sweep();
    chk("smooth_up", 64'(obs_pots[11:0]), 64'(12'h100));
    force_res[0] = 0;
    run_to_sweep();
    chk("smooth_down", 64'(obs_pots[11:0]), 64'(12'h0C0));

    // timeout on band 2, late completions in GAP ignored
    set_all(-3, -1);
    force_res[2] = 12'h123;
    do_reset(0);
    run_to_sweep();
    chk("pre_to_err", 64'(obs_err), 64'(0));
    force_lat[2] = -1;
    noise_en = 1;
    chq.delete();
    run_to_sweep();
    chk("to_err_set", 64'(obs_err), 64'(1));
    chk("to_band2_hold", 64'(obs_pots[24 +: 12]), 64'(12'h123));
    chk("to_len", 64'(chq.size()), 64'(NB));
    if (chq.size() > 3) chk("to_next_band", 64'(chq[3]), 64'(3));
    force_lat[2] = -3;
    run_to_sweep();
    chk("to_err_sticky", 64'(obs_err), 64'(1));
    noise_en = 0;

    // reset in the middle of band 3's WAIT, with a completion on the reset edge
    set_all(-3, -1);
    force_lat[3] = -1;
    n = 0;
    while (!(in_conv && band == 3 && cyc > req_cyc + 2) && n < 400) begin
      step();
      n++;
    end
    chk("reach_band3_wait", 64'(in_conv && band == 3), 64'(1));
    set_all(-3, -1);
    force_lat[0] = TO - 1;
    force_res[0] = 12'h5A5;
    do_reset(1);
    run_cycles(1);
    chk("midrst_pots", 64'(obs_pots), 64'(0));
    chk("midrst_strt", 64'(obs_strt), 64'(0));
    chk("midrst_err", 64'(obs_err), 64'(0));
    chk("midrst_chnnl", 64'(obs_chnnl), 64'(0));
    run_cycles(4);
    chk("midrst_first_strt", 64'(first_strt), 64'(4));

    // completion on the timeout-expiry cycle is a success
    run_to_sweep();
    chk("edge_capture", 64'(obs_pots[11:0]), 64'(12'h5A5));
    chk("edge_no_err", 64'(obs_err), 64'(0));

    // random traffic: latencies, timeouts, noise pulses and resets
    for (int r = 0; r < 4; r++) begin
      set_all(-2, -1);
      noise_en = 1;
      do_reset(1'($urandom_range(0, 1)));
      run_cycles(600 + int'($urandom_range(0, 200)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
